// File: rtl/sym_fir_pipe.sv
// Pipelined symmetric odd-length FIR with valid tagging and a double-buffered coefficient bank.
// Define SYM_FIR_SAT_EN to make the pre-adds and tree adds saturate instead of wrapping.

// Registered DW-bit add, wrapping or saturating depending on SYM_FIR_SAT_EN.
module sym_fir_add #(
  parameter int DW = 18
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] s
);
  logic signed [DW-1:0] nxt;

`ifdef SYM_FIR_SAT_EN
  logic signed [DW:0] sum;
  assign sum = a + b;
  always_comb begin
    nxt = sum[DW-1:0];
    if (sum[DW] != sum[DW-1])
      nxt = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end
`else
  assign nxt = a + b;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s <= '0;
    else          s <= nxt;
  end
endmodule

// One folded tap: pre-add of the mirrored pair, then product scaled by 2^-CF.
module sym_fir_tap #(
  parameter int DW = 18,
  parameter int CW = 18,
  parameter int CF = 17
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [DW-1:0] xa,
  input  logic signed [DW-1:0] xb,
  input  logic signed [CW-1:0] coef,
  output logic signed [DW-1:0] term
);
  logic signed [DW-1:0]    pre;
  logic signed [DW+CW-1:0] prod;

  sym_fir_add #(.DW(DW)) u_pre (
    .clk(clk), .reset_n(reset_n), .a(xa), .b(xb), .s(pre)
  );

  assign prod = pre * coef;

  // Arithmetic shift then keep the low DW bits: floor truncation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) term <= '0;
    else          term <= DW'(prod >>> CF);
  end
endmodule

module sym_fir_pipe #(
  parameter  int DW    = 18,
  parameter  int CW    = 18,
  parameter  int CF    = 17,
  parameter  int NTAPS = 31,
  localparam int M     = (NTAPS + 1) / 2,
  localparam int AW    = $clog2(M),
  localparam int T     = $clog2(M),
  localparam int LAT   = 3 + T
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] x_in,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_wdata,
  input  logic                 coef_commit,
  output logic                 out_valid,
  output logic signed [DW-1:0] y
);
  localparam int NL = 1 << T;
  localparam logic [M-1:0][CW-1:0] IDENT = {CW'(2**CF - 1), {((M-1)*CW){1'b0}}};
  localparam logic [AW:0] MA = (AW+1)'(M);

  logic [NTAPS-1:0][DW-1:0] xd;
  logic [M-1:0][CW-1:0]     shadow, bact;
  logic [M-1:0][DW-1:0]     term;
  logic [NL-1:0][DW-1:0]    leaf;
  logic [NL-1:0][DW-1:0]    node;
  logic [LAT:0]             vld_pipe;
  logic signed [DW-1:0]     xs;

  assign xs = x_in >>> 1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      xd <= '0;
    else if (in_valid) xd <= {xd[NTAPS-2:0], xs};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) shadow <= IDENT;
    else if (coef_we && ((AW+1)'(coef_addr) < MA)) shadow[coef_addr] <= coef_wdata;
  end

  // Commit samples the pre-edge shadow, so a same-cycle write lands only in shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         bact <= IDENT;
    else if (coef_commit) bact <= shadow;
  end

  for (genvar i = 0; i < M; i++) begin : g_tap
    logic signed [DW-1:0] xb;
    if (i == M-1) begin : g_ctr
      assign xb = '0;
    end else begin : g_pair
      assign xb = xd[NTAPS-1-i];
    end
    sym_fir_tap #(.DW(DW), .CW(CW), .CF(CF)) u_tap (
      .clk(clk), .reset_n(reset_n), .xa(xd[i]), .xb(xb),
      .coef(bact[i]), .term(term[i])
    );
  end

  for (genvar j = 0; j < NL; j++) begin : g_leaf
    if (j < M) begin : g_used
      assign leaf[j] = term[j];
    end else begin : g_pad
      assign leaf[j] = '0;
    end
  end

  // Heap-ordered tree: node 1 is the root, children of n are 2n and 2n+1.
  assign node[0] = '0;
  for (genvar n = 1; n < NL; n++) begin : g_node
    logic signed [DW-1:0] ca, cb;
    if (2*n >= NL) begin : g_bot
      assign ca = leaf[2*n-NL];
      assign cb = leaf[2*n+1-NL];
    end else begin : g_mid
      assign ca = node[2*n];
      assign cb = node[2*n+1];
    end
    sym_fir_add #(.DW(DW)) u_add (
      .clk(clk), .reset_n(reset_n), .a(ca), .b(cb), .s(node[n])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      y        <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-1:0], in_valid};
      if (vld_pipe[LAT-1]) y <= node[1];
    end
  end

  assign out_valid = vld_pipe[LAT];
endmodule
